// File: rtl/qbert_loader_pkg.sv
// Shared types and constants for the ROM download sequencer.
package qbert_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_READY = 3'd4
  } state_t;

  typedef logic [1:0] region_t;

  localparam region_t REG_CPU  = 2'd0;
  localparam region_t REG_TILE = 2'd1;
  localparam region_t REG_SPR  = 2'd2;
  localparam region_t REG_SND  = 2'd3;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // One-hot region select as seen by the board rom_init ports
  function automatic logic [3:0] region_onehot(input region_t r);
    logic [3:0] oh;
    case (r)
      REG_CPU:  oh = 4'b0001;
      REG_TILE: oh = 4'b0010;
      REG_SPR:  oh = 4'b0100;
      REG_SND:  oh = 4'b1000;
      default:  oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational region decode: picks the highest base not above the
// address, so the subtraction for the offset can never underflow.
module rom_region_decode
  import qbert_loader_pkg::*;
#(
  parameter int ADDR_W = 25
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] r1_base_i,
  input  logic [ADDR_W-1:0] r2_base_i,
  input  logic [ADDR_W-1:0] r3_base_i,
  input  logic [ADDR_W-1:0] r_end_i,
  output region_t           region_o,
  output logic [ADDR_W-1:0] offset_o,
  output logic              in_range_o
);

  // Region select and offset within the region
  always_comb begin
    region_o   = REG_CPU;
    offset_o   = addr_i;
    in_range_o = (addr_i < r_end_i);
    if (addr_i >= r3_base_i) begin
      region_o = REG_SND;
      offset_o = addr_i - r3_base_i;
    end else if (addr_i >= r2_base_i) begin
      region_o = REG_SPR;
      offset_o = addr_i - r2_base_i;
    end else if (addr_i >= r1_base_i) begin
      region_o = REG_TILE;
      offset_o = addr_i - r1_base_i;
    end else begin
      region_o = REG_CPU;
      offset_o = addr_i;
    end
  end

endmodule

// File: rtl/rom_load_sequencer.sv
// Steers the HPS ioctl download into the board ROM regions, captures the
// game-select and DIP bytes, and keeps the board in reset until the image
// is complete. One write is in flight at a time; ioctl_wait throttles HPS.
module rom_load_sequencer
  import qbert_loader_pkg::*;
#(
  parameter int                ADDR_W   = 25,
  parameter logic [ADDR_W-1:0] R1_BASE  = 25'h0010000,
  parameter logic [ADDR_W-1:0] R2_BASE  = 25'h0012000,
  parameter logic [ADDR_W-1:0] R3_BASE  = 25'h0022000,
  parameter logic [ADDR_W-1:0] R_END    = 25'h0023000,
  parameter int                POST_RST = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [3:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              board_reset,
  output logic              rom_loaded,
  output logic              load_error,
  output logic [7:0]        mod,
  output logic [7:0]        dip0
);

  localparam int CNT_W = (POST_RST > 1) ? $clog2(POST_RST) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(POST_RST - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              ioctl_wait_q, ioctl_wait_d;
  logic              mem_req_q, mem_req_d;
  logic [3:0]        mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              board_reset_q, board_reset_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              load_error_q, load_error_d;
  logic [7:0]        mod_q, mod_d;
  logic [7:0]        dip0_q, dip0_d;

  region_t           dec_region_s;
  logic [ADDR_W-1:0] dec_offset_s;
  logic              dec_in_range_s;
  logic              rom_start_s;
  logic              rom_wr_s;

  assign rom_start_s = ioctl_download && (ioctl_index == IDX_ROM);
  assign rom_wr_s    = ioctl_wr && (ioctl_index == IDX_ROM);

  rom_region_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr_i     (ioctl_addr),
    .r1_base_i  (R1_BASE),
    .r2_base_i  (R2_BASE),
    .r3_base_i  (R3_BASE),
    .r_end_i    (R_END),
    .region_o   (dec_region_s),
    .offset_o   (dec_offset_s),
    .in_range_o (dec_in_range_s)
  );

  // State and post-download reset counter registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter is loaded whenever HOLD is entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rom_start_s) state_d = ST_LOAD;
        else             state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (rom_wr_s && dec_in_range_s) begin
          state_d = ST_WRITE;
        end else if (!ioctl_download) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (!ioctl_download) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_HOLD: begin
        if (rom_start_s) begin
          state_d = ST_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_HOLD;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      ST_READY: begin
        if (rom_start_s) state_d = ST_LOAD;
        else             state_d = ST_READY;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, plus the index-1/254 captures
  always_comb begin
    ioctl_wait_d  = ioctl_wait_q;
    mem_req_d     = mem_req_q;
    mem_sel_d     = mem_sel_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    board_reset_d = board_reset_q;
    rom_loaded_d  = rom_loaded_q;
    load_error_d  = load_error_q;
    mod_d         = mod_q;
    dip0_d        = dip0_q;

    case (state_q)
      ST_IDLE, ST_READY: begin
        if (rom_start_s) begin
          rom_loaded_d  = 1'b0;
          load_error_d  = 1'b0;
          board_reset_d = 1'b1;
        end else begin
          board_reset_d = board_reset_q;
        end
      end
      ST_LOAD: begin
        if (rom_wr_s) begin
          if (dec_in_range_s) begin
            mem_req_d    = 1'b1;
            ioctl_wait_d = 1'b1;
            mem_sel_d    = region_onehot(dec_region_s);
            mem_addr_d   = dec_offset_s;
            mem_data_d   = ioctl_dout;
          end else begin
            load_error_d = 1'b1;
          end
        end else begin
          mem_req_d = 1'b0;
        end
      end
      ST_WRITE: begin
        // An extra strobe while a write is pending cannot be buffered
        if (rom_wr_s) load_error_d = 1'b1;
        else          load_error_d = load_error_q;
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          ioctl_wait_d = 1'b0;
          mem_sel_d    = 4'b0000;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (rom_start_s) begin
          rom_loaded_d  = 1'b0;
          load_error_d  = 1'b0;
          board_reset_d = 1'b1;
        end else if (cnt_q == '0) begin
          board_reset_d = 1'b0;
          rom_loaded_d  = 1'b1;
        end else begin
          board_reset_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
      end
    endcase

    if (ioctl_wr && (ioctl_index == IDX_MOD)) mod_d = ioctl_dout;
    else                                      mod_d = mod_q;

    if (ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr == '0)) dip0_d = ioctl_dout;
    else                                                              dip0_d = dip0_q;
  end

  // Output registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wait_q  <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_sel_q     <= 4'b0000;
      mem_addr_q    <= '0;
      mem_data_q    <= 8'h00;
      board_reset_q <= 1'b1;
      rom_loaded_q  <= 1'b0;
      load_error_q  <= 1'b0;
      mod_q         <= 8'hFF;
      dip0_q        <= 8'h00;
    end else begin
      ioctl_wait_q  <= ioctl_wait_d;
      mem_req_q     <= mem_req_d;
      mem_sel_q     <= mem_sel_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      board_reset_q <= board_reset_d;
      rom_loaded_q  <= rom_loaded_d;
      load_error_q  <= load_error_d;
      mod_q         <= mod_d;
      dip0_q        <= dip0_d;
    end
  end

  assign ioctl_wait  = ioctl_wait_q;
  assign mem_req     = mem_req_q;
  assign mem_sel     = mem_sel_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign board_reset = board_reset_q;
  assign rom_loaded  = rom_loaded_q;
  assign load_error  = load_error_q;
  assign mod         = mod_q;
  assign dip0        = dip0_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: a region table applied in a
// loop, hand sequences for overrun / download drop / captures / reset, and
// a scoreboard that checks every accepted memory write.
module tb_rom_load_sequencer;

  localparam int POST_RST = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_ack;
  logic [3:0]  mem_sel;
  logic [24:0] mem_addr;
  logic [7:0]  mem_data;
  logic        board_reset;
  logic        rom_loaded;
  logic        load_error;
  logic [7:0]  mod;
  logic [7:0]  dip0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  sel;
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [3:0]  sel;
    logic [24:0] off;
    logic        ok;
    logic        err;
  } vec_t;

  vec_t vecs[11];

  rom_load_sequencer dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_sel        (mem_sel),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .board_reset    (board_reset),
    .rom_loaded     (rom_loaded),
    .load_error     (load_error),
    .mod            (mod),
    .dip0           (dip0)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Scoreboard: every accepted write must match the oldest expectation
  always @(negedge clk_sys) begin : sb_mon
    exp_t e;
    if (!reset && mem_req && mem_ack) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got sel=%0h addr=%0h data=%0h expected no write",
                 mem_sel, mem_addr, mem_data);
      end else begin
        e = sb_q.pop_front();
        check("sb_sel", 32'(mem_sel), 32'(e.sel));
        check("sb_addr", 32'(mem_addr), 32'(e.addr));
        check("sb_data", 32'(mem_data), 32'(e.data));
      end
    end
  end

  task automatic drive_wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack_now();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
  endtask

  int wcnt;
  int fall_at;

  initial begin
    vecs[0]  = '{25'h0000000, 8'h11, 4'b0001, 25'h0000000, 1'b1, 1'b0};
    vecs[1]  = '{25'h000FFFF, 8'h22, 4'b0001, 25'h000FFFF, 1'b1, 1'b0};
    vecs[2]  = '{25'h0010000, 8'h33, 4'b0010, 25'h0000000, 1'b1, 1'b0};
    vecs[3]  = '{25'h0011FFF, 8'h44, 4'b0010, 25'h0001FFF, 1'b1, 1'b0};
    vecs[4]  = '{25'h0012000, 8'h55, 4'b0100, 25'h0000000, 1'b1, 1'b0};
    vecs[5]  = '{25'h0021FFF, 8'h66, 4'b0100, 25'h000FFFF, 1'b1, 1'b0};
    vecs[6]  = '{25'h0022000, 8'h77, 4'b1000, 25'h0000000, 1'b1, 1'b0};
    vecs[7]  = '{25'h0022FFF, 8'h88, 4'b1000, 25'h0000FFF, 1'b1, 1'b0};
    vecs[8]  = '{25'h0023000, 8'h99, 4'b0000, 25'h0000000, 1'b0, 1'b1};
    vecs[9]  = '{25'h1FFFFFF, 8'hAA, 4'b0000, 25'h0000000, 1'b0, 1'b1};
    vecs[10] = '{25'h0010001, 8'hBB, 4'b0010, 25'h0000001, 1'b1, 1'b1};

    reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = 25'h0; ioctl_dout = 8'h00; mem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset values
    check("rst_wait", 32'(ioctl_wait), 32'(1'b0));
    check("rst_req", 32'(mem_req), 32'(1'b0));
    check("rst_sel", 32'(mem_sel), 32'(4'b0000));
    check("rst_addr", 32'(mem_addr), 32'(25'h0));
    check("rst_data", 32'(mem_data), 32'(8'h00));
    check("rst_board_reset", 32'(board_reset), 32'(1'b1));
    check("rst_rom_loaded", 32'(rom_loaded), 32'(1'b0));
    check("rst_load_error", 32'(load_error), 32'(1'b0));
    check("rst_mod", 32'(mod), 32'(8'hFF));
    check("rst_dip0", 32'(dip0), 32'(8'h00));

    // Start ROM download; first write acked after 3 cycles
    ioctl_download = 1'b1; ioctl_index = 8'd0;
    tick();
    sb_q.push_back('{4'b0001, 25'h0, 8'hA5});
    drive_wr(25'h0, 8'hA5);
    wcnt = 0;
    if (ioctl_wait) wcnt++;
    check("t1_req_latency", 32'(mem_req), 32'(1'b1));
    check("t1_sel", 32'(mem_sel), 32'(4'b0001));
    check("t1_addr", 32'(mem_addr), 32'(25'h0));
    check("t1_data", 32'(mem_data), 32'(8'hA5));
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ioctl_wait) wcnt++;
      check("t1_sel_hold", 32'(mem_sel), 32'(4'b0001));
    end
    ack_now();
    if (ioctl_wait) wcnt++;
    check("t1_wait_cycles", 32'(wcnt), 32'(4));
    check("t1_req_done", 32'(mem_req), 32'(1'b0));
    check("t1_sel_done", 32'(mem_sel), 32'(4'b0000));

    // Overrun: second strobe while the first write is pending
    sb_q.push_back('{4'b0001, 25'h0000100, 8'h11});
    drive_wr(25'h0000100, 8'h11);
    drive_wr(25'h0000200, 8'h77);
    check("t5_err", 32'(load_error), 32'(1'b1));
    check("t5_data_kept", 32'(mem_data), 32'(8'h11));
    check("t5_addr_kept", 32'(mem_addr), 32'(25'h0000100));
    check("t5_req_kept", 32'(mem_req), 32'(1'b1));
    ack_now();
    check("t5_req_done", 32'(mem_req), 32'(1'b0));

    // Restart the download from HOLD, which clears the sticky error
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    check("restart_err_clear", 32'(load_error), 32'(1'b0));
    check("restart_board_reset", 32'(board_reset), 32'(1'b1));

    // Region table
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].ok) sb_q.push_back('{vecs[i].sel, vecs[i].off, vecs[i].data});
      drive_wr(vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_req", i), 32'(mem_req), 32'(vecs[i].ok));
      check($sformatf("v%0d_wait", i), 32'(ioctl_wait), 32'(vecs[i].ok));
      if (vecs[i].ok) begin
        check($sformatf("v%0d_sel", i), 32'(mem_sel), 32'(vecs[i].sel));
        check($sformatf("v%0d_off", i), 32'(mem_addr), 32'(vecs[i].off));
        for (int k = 0; k < (i % 3); k++) tick();
        ack_now();
        check($sformatf("v%0d_req_done", i), 32'(mem_req), 32'(1'b0));
      end
      check($sformatf("v%0d_err", i), 32'(load_error), 32'(vecs[i].err));
    end

    // Download falls while a write is pending; ack two cycles later
    sb_q.push_back('{4'b0010, 25'h0000234, 8'h5A});
    drive_wr(25'h0010234, 8'h5A);
    ioctl_download = 1'b0;
    tick(); tick();
    check("t4_req_pending", 32'(mem_req), 32'(1'b1));
    ack_now();
    check("t4_req_done", 32'(mem_req), 32'(1'b0));
    check("t4_board_reset_held", 32'(board_reset), 32'(1'b1));
    fall_at = -1;
    for (int k = 1; k <= POST_RST + 4; k++) begin
      tick();
      if (fall_at < 0 && !board_reset) fall_at = k;
    end
    check("t4_reset_fall_cycle", 32'(fall_at), 32'(POST_RST));
    check("t4_rom_loaded", 32'(rom_loaded), 32'(1'b1));

    // Side-band captures
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    drive_wr(25'h0, 8'h22);
    drive_wr(25'h1, 8'h05);
    ioctl_index = 8'd254;
    drive_wr(25'h1, 8'h99);
    drive_wr(25'h0, 8'h3C);
    drive_wr(25'h2, 8'h41);
    ioctl_download = 1'b0;
    tick();
    check("t6_mod", 32'(mod), 32'(8'h05));
    check("t6_dip0", 32'(dip0), 32'(8'h3C));
    check("t6_no_req", 32'(mem_req), 32'(1'b0));
    check("t6_no_wait", 32'(ioctl_wait), 32'(1'b0));
    check("t6_still_loaded", 32'(rom_loaded), 32'(1'b1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_mod", 32'(mod), 32'(8'hFF));
    check("t6_rst_dip0", 32'(dip0), 32'(8'h00));
    check("t6_rst_board_reset", 32'(board_reset), 32'(1'b1));
    check("t6_rst_rom_loaded", 32'(rom_loaded), 32'(1'b0));

    // Reset in the middle of a pending write abandons it
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    tick();
    drive_wr(25'h0022010, 8'hE7);
    check("mid_req", 32'(mem_req), 32'(1'b1));
    reset = 1'b1;
    tick();
    check("mid_rst_req", 32'(mem_req), 32'(1'b0));
    check("mid_rst_wait", 32'(ioctl_wait), 32'(1'b0));
    check("mid_rst_sel", 32'(mem_sel), 32'(4'b0000));
    check("mid_rst_data", 32'(mem_data), 32'(8'h00));
    reset = 1'b0; ioctl_download = 1'b0;
    tick(); tick();

    check("sb_empty", 32'(sb_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
